bi_set_counter_bank: RTL and testbench
======================================

Name: bi_set_counter_bank

Overview:
Bank of CHANNELS independent event counters on the BiSet register bus, replacing per-signal single counters.
- Width and wrap/saturate mode are parametrised; clear-on-read is optional.
- Sticky per-channel overflow flags in a status register.
- Global enable/clear control register.
- Sits beside a block's status logic, counting pulses (errors, drops, handshakes) for software polling.

Parameters:
ADDR, 0, BiSet address of channel 0; channel k at ADDR+k, status at ADDR+CHANNELS, control at ADDR+CHANNELS+1
CHANNELS, 4, number of counters; legal 1..32
WIDTH, 32, counter width in bits; legal 1..32
WRAP, 0, 0 = saturate at 2**WIDTH-1, 1 = wrap to 0
CLEAR_ON_READ, 1, 1 = reading a channel clears it, 0 = reads are non-destructive

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, synchronous, active-low
inc_i  input  CHANNELS  per-channel count pulse, one increment per cycle high
setCtrl_i  input  BiSet::biSetCtrl  register bus request (address, write enable, write data)
setReply_o  output  BiSet::biSetReply  register bus reply, '0 when not replying

Behaviour:
- Elaboration: CHANNELS or WIDTH outside its legal range, or WRAP/CLEAR_ON_READ not 0/1, instantiates PanicModule.
- Reset: sampled at clk_i rising edge with rst_ni=0.
  - Counters = 0, overflow flags = 0, enable = 1, pending read = none.
  - setReply_o = '0 from the following cycle.
  - A read pending at reset is dropped.
- Decode: a request matches if BiSetCtrlAddr is in ADDR..ADDR+CHANNELS+1. Unmatched requests are ignored.
- Read latency: 1 cycle.
  - Read request in cycle N is registered at the end of N.
  - In cycle N+1, setReply_o = BiSetDataReply(value zero-extended to 32 bits).
  - All other cycles setReply_o = '0.
  - Back-to-back reads are allowed, one per cycle.
- Channel read data: counter value at cycle N+1. Status read data: overflow flags in bits CHANNELS-1:0, upper bits 0. Control read data: bit0 = enable, upper bits 0.
- Writes take effect at the clock edge ending the request cycle.
  - Control write: bit0 -> enable. bit1 = 1 clears all counters and all flags (self-clearing, always reads 0).
  - Writes to channel and status addresses are ignored.
- Counter update priority per channel, per edge (highest first):
  - reset
  - clear-all: counter = 0, inc dropped
  - read-clear (CLEAR_ON_READ=1, edge ending cycle N+1 of that channel's read): counter = (inc_i & enable) ? 1 : 0, so no event is lost
  - count: if inc_i & enable, counter += 1 with overflow rule
  - otherwise hold
- Overflow rule at counter = 2**WIDTH-1 with an accepted inc:
  - WRAP=0: counter holds at max, flag set.
  - WRAP=1: counter becomes 0, flag set.
- Overflow flags: sticky.
  - Reading the status register clears all flags at the edge ending the reply cycle.
  - An overflow event on that same edge leaves its flag set (new event wins over clear).
- Enable = 0: inc_i ignored, no flag updates. Reads, read-clear and clear-all still operate.
- CLEAR_ON_READ=0: channel reads never modify the counter.
- Reading the control or status register never affects counters.

Test Plan:
- Reset and hold: assert rst_ni=0 for 2 cycles with inc_i all high -> all channels read 0, status 0, control reads 0x1, setReply_o '0 outside reply cycles.
- Count and clear-on-read: pulse inc_i[1] 5 times, then read ADDR+1 -> reply 5 one cycle after the request. With inc_i[1] high during the reply cycle, the next read returns 1. Channel 0 reads 0 throughout.
- Saturate/wrap at WIDTH=4: 17 pulses on ch0 with WRAP=0 -> reads 15, status 0x1. Same stimulus with WRAP=1 -> reads 1, status 0x1. A second status read returns 0x0.
- Overflow race: WRAP=1, WIDTH=4. Counter at 15 and inc on the same edge as the status-read clear -> status read returns the old flags, a subsequent status read returns bit0 = 1.
- Control: write 0x0 -> inc ignored, counters hold. Write 0x3 -> counters and flags become 0 and counting resumes; a concurrent inc on that edge is dropped. Control then reads 0x1.
- Non-destructive mode: CLEAR_ON_READ=0, 3 pulses, two back-to-back reads -> replies 3 then 3 in consecutive cycles. Reset asserted during a pending read -> setReply_o '0 in the following cycle.

Source files
------------

// File: rtl/bi_set_counter_bank.sv
// bi_set_counter_bank: bank of pulse counters with sticky overflow flags on the BiSet register bus.
// Also provides the BiSet bus types and the elaboration-time PanicModule.
package BiSet;
    typedef struct packed {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } biSetCtrl;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } biSetReply;

    function automatic logic [31:0] BiSetCtrlAddr(input biSetCtrl c);
        return c.addr;
    endfunction

    function automatic biSetReply BiSetDataReply(input logic [31:0] d);
        biSetReply r;
        r.valid = 1'b1;
        r.data  = d;
        return r;
    endfunction
endpackage

module PanicModule;
endmodule

module bi_set_counter_bank #(
    parameter int ADDR          = 0,
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 32,
    parameter int WRAP          = 0,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CHANNELS-1:0] inc_i,
    input  BiSet::biSetCtrl     setCtrl_i,
    output BiSet::biSetReply    setReply_o
);
    localparam logic [WIDTH-1:0] MAX = '1;

    if (CHANNELS < 1 || CHANNELS > 32 || WIDTH < 1 || WIDTH > 32 ||
        (WRAP != 0 && WRAP != 1) || (CLEAR_ON_READ != 0 && CLEAR_ON_READ != 1)) begin : g_panic
        PanicModule u_panic();
    end

    logic [31:0]         off;
    logic                hit;
    logic                rd_req;
    logic                ctrl_wr;
    logic                clr_all;
    logic                pend;
    logic [5:0]          pend_off;
    logic                en;
    logic                st_clr;
    logic [WIDTH-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] ovf;
    logic [CHANNELS-1:0] ovf_evt;
    logic [31:0]         rd_data;
    logic                unused_data;

    assign off         = BiSet::BiSetCtrlAddr(setCtrl_i) - 32'(ADDR);
    assign hit         = off < 32'(CHANNELS + 2);
    assign rd_req      = setCtrl_i.en & ~setCtrl_i.we & hit;
    assign ctrl_wr     = setCtrl_i.en & setCtrl_i.we & (off == 32'(CHANNELS + 1));
    assign clr_all     = ctrl_wr & setCtrl_i.data[1];
    assign st_clr      = pend && pend_off == 6'(CHANNELS);
    assign unused_data = ^setCtrl_i.data[31:2];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic take;
        logic rd_clr;
        assign take       = inc_i[c] & en;
        assign rd_clr     = CLEAR_ON_READ == 1 && pend && pend_off == 6'(c);
        assign ovf_evt[c] = take & ~clr_all & ~rd_clr & (cnt[c] == MAX);
        // Read-clear reloads with the concurrent pulse so no event is lost.
        always_ff @(posedge clk_i) begin
            if (!rst_ni)
                cnt[c] <= '0;
            else if (clr_all)
                cnt[c] <= '0;
            else if (rd_clr)
                cnt[c] <= take ? WIDTH'(1) : '0;
            else if (take)
                cnt[c] <= (cnt[c] == MAX && WRAP == 0) ? MAX : cnt[c] + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf      <= '0;
            en       <= 1'b1;
            pend     <= 1'b0;
            pend_off <= '0;
        end else begin
            ovf      <= clr_all ? '0 : ((st_clr ? '0 : ovf) | ovf_evt);
            en       <= ctrl_wr ? setCtrl_i.data[0] : en;
            pend     <= rd_req;
            pend_off <= off[5:0];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (pend_off == 6'(k)) rd_data = 32'(cnt[k]);
        if (pend_off == 6'(CHANNELS)) rd_data = 32'(ovf);
        if (pend_off == 6'(CHANNELS + 1)) rd_data = {31'b0, en};
        setReply_o = pend ? BiSet::BiSetDataReply(rd_data) : '0;
    end
endmodule

// File: tb/tb_bi_set_counter_bank.sv
// tb_bi_set_counter_bank: directed and randomized checks of three differently configured counter banks
// driven with the same register offsets and pulses, against a behavioural model.
module tb_bi_set_counter_bank;
    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic [3:0]       inc = '0;
    BiSet::biSetCtrl  ctrl [3];
    BiSet::biSetReply reply [3];
    BiSet::biSetReply got [3];
    BiSet::biSetReply want [3];

    int checks = 0;
    int errors = 0;

    int base [3] = '{0, 100, 7};
    int wid  [3] = '{4, 4, 5};
    int wrp  [3] = '{0, 1, 0};
    int cor  [3] = '{1, 1, 0};

    int unsigned mc [3][4];
    bit [3:0]    mo [3];
    bit          me [3];
    bit          mp [3];
    int          mpo [3];
    int unsigned e [3];

    always #5 clk = ~clk;

    bi_set_counter_bank #(.ADDR(0), .CHANNELS(4), .WIDTH(4), .WRAP(0), .CLEAR_ON_READ(1)) u0 (
        .clk_i(clk), .rst_ni(rst_ni), .inc_i(inc), .setCtrl_i(ctrl[0]), .setReply_o(reply[0]));
    bi_set_counter_bank #(.ADDR(100), .CHANNELS(4), .WIDTH(4), .WRAP(1), .CLEAR_ON_READ(1)) u1 (
        .clk_i(clk), .rst_ni(rst_ni), .inc_i(inc), .setCtrl_i(ctrl[1]), .setReply_o(reply[1]));
    bi_set_counter_bank #(.ADDR(7), .CHANNELS(4), .WIDTH(5), .WRAP(0), .CLEAR_ON_READ(0)) u2 (
        .clk_i(clk), .rst_ni(rst_ni), .inc_i(inc), .setCtrl_i(ctrl[2]), .setReply_o(reply[2]));

    function automatic BiSet::biSetReply rep(input int unsigned v);
        BiSet::biSetReply r;
        r.valid = 1'b1;
        r.data  = v;
        return r;
    endfunction

    // kind: 0 idle, 1 read, 2 write; off is relative to each bank's base address.
    task step(input logic [3:0] iv, input int kind, input int off, input logic [31:0] d);
        int unsigned mx;
        bit clr, take, rdclr, stclr;
        bit [3:0] evt;
        inc = iv;
        for (int i = 0; i < 3; i++) begin
            ctrl[i].en   = (kind != 0);
            ctrl[i].we   = (kind == 2);
            ctrl[i].addr = 32'(base[i] + off);
            ctrl[i].data = d;
        end
        #4;
        for (int i = 0; i < 3; i++) begin
            got[i]  = reply[i];
            want[i] = '0;
            if (mp[i]) begin
                if (mpo[i] < 4) want[i] = rep(mc[i][mpo[i]]);
                else if (mpo[i] == 4) want[i] = rep(32'(mo[i]));
                else want[i] = rep(32'(me[i]));
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!rst_ni) begin
                for (int k = 0; k < 4; k++) mc[i][k] = 0;
                mo[i] = '0;
                me[i] = 1'b1;
                mp[i] = 1'b0;
            end else begin
                mx  = (32'd1 << wid[i]) - 1;
                clr = kind == 2 && off == 5 && d[1];
                evt = '0;
                for (int k = 0; k < 4; k++) begin
                    take  = iv[k] && me[i];
                    rdclr = cor[i] == 1 && mp[i] && mpo[i] == k;
                    if (clr) mc[i][k] = 0;
                    else if (rdclr) mc[i][k] = take ? 1 : 0;
                    else if (take) begin
                        if (mc[i][k] == mx) begin
                            evt[k] = 1'b1;
                            mc[i][k] = wrp[i] == 1 ? 0 : mx;
                        end else mc[i][k] = mc[i][k] + 1;
                    end
                end
                stclr = mp[i] && mpo[i] == 4;
                mo[i] = clr ? 4'b0 : ((stclr ? 4'b0 : mo[i]) | evt);
                if (kind == 2 && off == 5) me[i] = d[0];
                mp[i]  = kind == 1 && off >= 0 && off <= 5;
                mpo[i] = off;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task rd(input int off, input logic [3:0] iv);
        step(4'b0, 1, off, 32'h0);
        step(iv, 0, 0, 32'h0);
    endtask

    task test_reset;
        rst_ni = 1'b0;
        step(4'hf, 0, 0, 32'h0);
        step(4'hf, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== '0) begin
                errors++;
                $display("FAIL reset_idle u%0d: got %h want %h", i, got[i], 33'h0);
            end
        end
        rst_ni = 1'b1;
        for (int off = 0; off < 6; off++) begin
            rd(off, 4'h0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== rep(off == 5 ? 1 : 0)) begin
                    errors++;
                    $display("FAIL reset_reg%0d u%0d: got %h want %h", off, i, got[i], rep(off == 5 ? 1 : 0));
                end
            end
        end
        step(4'h0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== '0) begin
                errors++;
                $display("FAIL reset_noreply u%0d: got %h want %h", i, got[i], 33'h0);
            end
        end
    endtask

    task test_count_clear;
        for (int n = 0; n < 5; n++) step(4'b0010, 0, 0, 32'h0);
        rd(1, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(5)) begin
                errors++;
                $display("FAIL count_first u%0d: got %h want %h", i, got[i], rep(5));
            end
        end
        e = '{1, 1, 6};
        rd(1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(e[i])) begin
                errors++;
                $display("FAIL count_second u%0d: got %h want %h", i, got[i], rep(e[i]));
            end
        end
        rd(0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(0)) begin
                errors++;
                $display("FAIL count_ch0 u%0d: got %h want %h", i, got[i], rep(0));
            end
        end
    endtask

    task test_saturate_wrap;
        step(4'b0, 2, 5, 32'h3);
        for (int n = 0; n < 17; n++) step(4'b0001, 0, 0, 32'h0);
        e = '{15, 1, 17};
        rd(0, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(e[i])) begin
                errors++;
                $display("FAIL sat_value u%0d: got %h want %h", i, got[i], rep(e[i]));
            end
        end
        e = '{1, 1, 0};
        rd(4, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(e[i])) begin
                errors++;
                $display("FAIL sat_status u%0d: got %h want %h", i, got[i], rep(e[i]));
            end
        end
        rd(4, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(0)) begin
                errors++;
                $display("FAIL sat_status_clr u%0d: got %h want %h", i, got[i], rep(0));
            end
        end
    endtask

    task test_overflow_race;
        step(4'b0, 2, 5, 32'h3);
        for (int n = 0; n < 15; n++) step(4'b0001, 0, 0, 32'h0);
        rd(4, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(0)) begin
                errors++;
                $display("FAIL race_old u%0d: got %h want %h", i, got[i], rep(0));
            end
        end
        e = '{1, 1, 0};
        rd(4, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(e[i])) begin
                errors++;
                $display("FAIL race_new u%0d: got %h want %h", i, got[i], rep(e[i]));
            end
        end
    endtask

    task test_control;
        step(4'b0, 2, 5, 32'h0);
        for (int n = 0; n < 3; n++) step(4'b0101, 0, 0, 32'h0);
        rd(2, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(0)) begin
                errors++;
                $display("FAIL ctrl_hold u%0d: got %h want %h", i, got[i], rep(0));
            end
        end
        rd(4, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(0)) begin
                errors++;
                $display("FAIL ctrl_noflag u%0d: got %h want %h", i, got[i], rep(0));
            end
        end
        rd(5, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(0)) begin
                errors++;
                $display("FAIL ctrl_off u%0d: got %h want %h", i, got[i], rep(0));
            end
        end
        step(4'b0, 2, 5, 32'h1);
        step(4'b0101, 0, 0, 32'h0);
        step(4'b0101, 0, 0, 32'h0);
        step(4'b0101, 2, 5, 32'h3);
        rd(5, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(1)) begin
                errors++;
                $display("FAIL ctrl_on u%0d: got %h want %h", i, got[i], rep(1));
            end
        end
        rd(4, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(0)) begin
                errors++;
                $display("FAIL ctrl_clr_flags u%0d: got %h want %h", i, got[i], rep(0));
            end
        end
        rd(2, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(0)) begin
                errors++;
                $display("FAIL ctrl_clr_cnt u%0d: got %h want %h", i, got[i], rep(0));
            end
        end
        step(4'b0100, 0, 0, 32'h0);
        rd(2, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(1)) begin
                errors++;
                $display("FAIL ctrl_resume u%0d: got %h want %h", i, got[i], rep(1));
            end
        end
    endtask

    task test_back_to_back;
        step(4'b0, 2, 5, 32'h3);
        for (int n = 0; n < 3; n++) step(4'b1000, 0, 0, 32'h0);
        step(4'b0, 1, 3, 32'h0);
        step(4'b0, 1, 3, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(3)) begin
                errors++;
                $display("FAIL b2b_first u%0d: got %h want %h", i, got[i], rep(3));
            end
        end
        e = '{0, 0, 3};
        step(4'b0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(e[i])) begin
                errors++;
                $display("FAIL b2b_second u%0d: got %h want %h", i, got[i], rep(e[i]));
            end
        end
        step(4'b0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== '0) begin
                errors++;
                $display("FAIL b2b_idle u%0d: got %h want %h", i, got[i], 33'h0);
            end
        end
    endtask

    task test_reset_pending;
        step(4'b0, 1, 3, 32'h0);
        rst_ni = 1'b0;
        step(4'b0, 0, 0, 32'h0);
        rst_ni = 1'b1;
        step(4'b0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== '0) begin
                errors++;
                $display("FAIL rst_pending u%0d: got %h want %h", i, got[i], 33'h0);
            end
        end
        rd(3, 4'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== rep(0)) begin
                errors++;
                $display("FAIL rst_cnt u%0d: got %h want %h", i, got[i], rep(0));
            end
        end
    endtask

    task test_random;
        int kind;
        logic [31:0] d;
        for (int n = 0; n < 800; n++) begin
            rst_ni = ($urandom_range(0, 149) != 0);
            kind = $urandom_range(0, 19);
            kind = kind < 8 ? 0 : (kind < 17 ? 1 : 2);
            d = $urandom;
            d[0] = ($urandom_range(0, 3) != 0);
            d[1] = ($urandom_range(0, 7) == 0);
            step(4'($urandom), kind, $urandom_range(0, 7) - 1, d);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("FAIL random_c%0d u%0d: got %h want %h", n, i, got[i], want[i]);
                end
            end
        end
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            ctrl[i] = '0;
            mp[i] = 1'b0;
            me[i] = 1'b1;
            mo[i] = '0;
        end
        @(posedge clk);
        #1;
        test_reset;
        test_count_clear;
        test_saturate_wrap;
        test_overflow_race;
        test_control;
        test_back_to_back;
        test_reset_pending;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
